// File: rtl/bp_io_cmd_arbiter.sv
// Round-robin arbiter sharing one uncached I/O command port among num_req_p sources.
// Issued source IDs are kept in an in-order tag FIFO to steer responses back.
module bp_io_cmd_arbiter #(
    parameter int num_req_p         = 4,
    parameter int msg_width_p       = 128,
    parameter int max_outstanding_p = 4
) (
    input  logic                           clk_i,
    input  logic                           reset_n_i,
    input  logic [num_req_p*msg_width_p-1:0] req_cmd_i,
    input  logic [num_req_p-1:0]           req_cmd_v_i,
    output logic [num_req_p-1:0]           req_cmd_yumi_o,
    output logic [msg_width_p-1:0]         req_resp_o,
    output logic [num_req_p-1:0]           req_resp_v_o,
    input  logic [num_req_p-1:0]           req_resp_ready_i,
    output logic [msg_width_p-1:0]         io_cmd_o,
    output logic                           io_cmd_v_o,
    input  logic                           io_cmd_yumi_i,
    input  logic [msg_width_p-1:0]         io_resp_i,
    input  logic                           io_resp_v_i,
    output logic                           io_resp_yumi_o,
    output logic                           error_o
);
    localparam int id_w_lp  = (num_req_p > 1) ? $clog2(num_req_p) : 1;
    localparam int cnt_w_lp = $clog2(max_outstanding_p + 1);
    localparam int ptr_w_lp = (max_outstanding_p > 1) ? $clog2(max_outstanding_p) : 1;

    localparam logic [id_w_lp:0]     num_req_lp  = (id_w_lp + 1)'(num_req_p);
    localparam logic [id_w_lp-1:0]   last_id_lp  = id_w_lp'(num_req_p - 1);
    localparam logic [ptr_w_lp-1:0]  last_ptr_lp = ptr_w_lp'(max_outstanding_p - 1);
    localparam logic [cnt_w_lp-1:0]  max_cnt_lp  = cnt_w_lp'(max_outstanding_p);

    logic [id_w_lp-1:0]  rr_ptr;
    logic                lock_v;
    logic [id_w_lp-1:0]  lock_id;
    logic [id_w_lp-1:0]  tag_q [max_outstanding_p];
    logic [ptr_w_lp-1:0] wr_ptr, rd_ptr;
    logic [cnt_w_lp-1:0] count;
    logic                error_r;

    logic [id_w_lp-1:0]  sel_scan, sel, sel_inc, head;
    logic [id_w_lp:0]    scan_idx;
    logic                scan_found;
    logic                credit, cmd_v, cmd_issue;
    logic                fifo_empty, resp_pending, resp_pop, err_set;

    function automatic logic [ptr_w_lp-1:0] ptr_inc(input logic [ptr_w_lp-1:0] p);
        return (p == last_ptr_lp) ? '0 : p + 1'b1;
    endfunction

    // First valid requester at or above rr_ptr, wrapping modulo num_req_p.
    always_comb begin
        sel_scan   = rr_ptr;
        scan_idx   = '0;
        scan_found = 1'b0;
        for (int i = 0; i < num_req_p; i++) begin
            scan_idx = {1'b0, rr_ptr} + (id_w_lp + 1)'(i);
            if (scan_idx >= num_req_lp) begin
                scan_idx = scan_idx - num_req_lp;
            end
            if (!scan_found && req_cmd_v_i[scan_idx[id_w_lp-1:0]]) begin
                scan_found = 1'b1;
                sel_scan   = scan_idx[id_w_lp-1:0];
            end
        end
    end

    assign sel     = lock_v ? lock_id : sel_scan;
    assign sel_inc = (sel == last_id_lp) ? '0 : sel + 1'b1;

    // Credit uses the registered count so a same-cycle pop never frees a slot.
    assign credit    = (count < max_cnt_lp);
    assign cmd_v     = credit & (lock_v | (|req_cmd_v_i));
    assign cmd_issue = io_cmd_yumi_i & cmd_v;

    assign io_cmd_v_o = cmd_v & reset_n_i;
    assign io_cmd_o   = req_cmd_i[sel*msg_width_p +: msg_width_p];

    always_comb begin
        req_cmd_yumi_o = '0;
        for (int k = 0; k < num_req_p; k++) begin
            req_cmd_yumi_o[k] = cmd_issue && reset_n_i && (sel == id_w_lp'(k));
        end
    end

    assign head         = tag_q[rd_ptr];
    assign fifo_empty   = (count == '0);
    assign resp_pending = io_resp_v_i & ~fifo_empty;
    assign resp_pop     = resp_pending & req_resp_ready_i[head];

    assign req_resp_o     = io_resp_i;
    assign io_resp_yumi_o = resp_pop;

    always_comb begin
        req_resp_v_o = '0;
        for (int k = 0; k < num_req_p; k++) begin
            req_resp_v_o[k] = resp_pending && (head == id_w_lp'(k));
        end
    end

    assign err_set = (io_resp_v_i & fifo_empty) | (io_cmd_yumi_i & ~cmd_v);
    assign error_o = error_r;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            rr_ptr  <= '0;
            lock_v  <= 1'b0;
            lock_id <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            error_r <= 1'b0;
            for (int i = 0; i < max_outstanding_p; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            if (cmd_issue) begin
                rr_ptr        <= sel_inc;
                lock_v        <= 1'b0;
                tag_q[wr_ptr] <= sel;
                wr_ptr        <= ptr_inc(wr_ptr);
            end else if (cmd_v) begin
                lock_v  <= 1'b1;
                lock_id <= sel;
            end

            if (resp_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end

            case ({cmd_issue, resp_pop})
                2'b10:   count <= count + cnt_w_lp'(1);
                2'b01:   count <= count - cnt_w_lp'(1);
                default: count <= count;
            endcase

            if (err_set) begin
                error_r <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_bp_io_cmd_arbiter.sv
// Directed bench for bp_io_cmd_arbiter: fairness, lock, credit, backpressure,
// protocol errors and asynchronous reset, with hand-computed expectations.
module tb_bp_io_cmd_arbiter;
    localparam int n_lp = 4;
    localparam int w_lp = 16;
    localparam int m_lp = 4;

    logic                  clk_i = 1'b0;
    logic                  reset_n_i;
    logic [n_lp*w_lp-1:0]  req_cmd_i;
    logic [n_lp-1:0]       req_cmd_v_i;
    logic [n_lp-1:0]       req_cmd_yumi_o;
    logic [w_lp-1:0]       req_resp_o;
    logic [n_lp-1:0]       req_resp_v_o;
    logic [n_lp-1:0]       req_resp_ready_i;
    logic [w_lp-1:0]       io_cmd_o;
    logic                  io_cmd_v_o;
    logic                  io_cmd_yumi_i;
    logic [w_lp-1:0]       io_resp_i;
    logic                  io_resp_v_i;
    logic                  io_resp_yumi_o;
    logic                  error_o;

    int n_checks = 0;
    int n_fails  = 0;

    bp_io_cmd_arbiter #(
        .num_req_p(n_lp), .msg_width_p(w_lp), .max_outstanding_p(m_lp)
    ) dut (
        .clk_i(clk_i), .reset_n_i(reset_n_i),
        .req_cmd_i(req_cmd_i), .req_cmd_v_i(req_cmd_v_i), .req_cmd_yumi_o(req_cmd_yumi_o),
        .req_resp_o(req_resp_o), .req_resp_v_o(req_resp_v_o), .req_resp_ready_i(req_resp_ready_i),
        .io_cmd_o(io_cmd_o), .io_cmd_v_o(io_cmd_v_o), .io_cmd_yumi_i(io_cmd_yumi_i),
        .io_resp_i(io_resp_i), .io_resp_v_i(io_resp_v_i), .io_resp_yumi_o(io_resp_yumi_o),
        .error_o(error_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [w_lp-1:0] cmd(input int k);
        return 16'hC000 | 16'(k);
    endfunction

    function automatic logic [31:0] oh(input int k);
        return 32'(1) << k;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change 2 time units after the rising edge; checks follow 1 unit later.
    task automatic cyc();
        @(posedge clk_i);
        #2;
        req_cmd_v_i      = '0;
        io_cmd_yumi_i    = 1'b0;
        io_resp_v_i      = 1'b0;
        req_resp_ready_i = '1;
    endtask

    int heads_a [3] = '{2, 0, 2};
    int heads_b [3] = '{2, 3, 0};

    initial begin
        reset_n_i        = 1'b0;
        req_cmd_v_i      = '0;
        io_cmd_yumi_i    = 1'b0;
        io_resp_v_i      = 1'b0;
        io_resp_i        = '0;
        req_resp_ready_i = '1;
        for (int k = 0; k < n_lp; k++) req_cmd_i[k*w_lp +: w_lp] = cmd(k);

        #3;
        req_cmd_v_i   = '1;
        io_cmd_yumi_i = 1'b1;
        io_resp_v_i   = 1'b1;
        #1;
        chk("rst_cmd_v", 32'(io_cmd_v_o), 0);
        chk("rst_cmd_yumi", 32'(req_cmd_yumi_o), 0);
        chk("rst_resp_v", 32'(req_resp_v_o), 0);
        chk("rst_resp_yumi", 32'(io_resp_yumi_o), 0);
        chk("rst_error", 32'(error_o), 0);

        cyc();
        cyc();
        reset_n_i = 1'b1;

        // Fairness: all valid, yumi every cycle, responses two cycles behind.
        for (int i = 0; i < 10; i++) begin
            cyc();
            if (i < 8) begin
                req_cmd_v_i   = '1;
                io_cmd_yumi_i = 1'b1;
            end
            io_resp_v_i = (i >= 2);
            io_resp_i   = 16'h5000 + 16'(i);
            #1;
            if (i < 8) begin
                chk("fair_cmd_v", 32'(io_cmd_v_o), 1);
                chk("fair_cmd", 32'(io_cmd_o), 32'(cmd(i % 4)));
                chk("fair_yumi", 32'(req_cmd_yumi_o), oh(i % 4));
            end
            if (i >= 2) begin
                chk("fair_resp_v", 32'(req_resp_v_o), oh((i - 2) % 4));
                chk("fair_resp_yumi", 32'(io_resp_yumi_o), 1);
                chk("fair_resp_data", 32'(req_resp_o), 32'h5000 + 32'(i));
            end
        end

        // Move rr_ptr to 2 by issuing requester 1, then drain its response.
        cyc(); req_cmd_v_i = 4'b0010; io_cmd_yumi_i = 1'b1; #1;
        chk("pre_cmd", 32'(io_cmd_o), 32'(cmd(1)));
        chk("pre_yumi", 32'(req_cmd_yumi_o), 32'b0010);
        cyc(); io_resp_v_i = 1'b1; #1;
        chk("pre_resp_v", 32'(req_resp_v_o), 32'b0010);
        chk("pre_resp_yumi", 32'(io_resp_yumi_o), 1);

        // Lock: requester 2 stalls three cycles, requester 0 arrives meanwhile.
        for (int s = 0; s < 3; s++) begin
            cyc(); req_cmd_v_i = (s == 0) ? 4'b0100 : 4'b0101; #1;
            chk("lock_cmd_v", 32'(io_cmd_v_o), 1);
            chk("lock_cmd", 32'(io_cmd_o), 32'(cmd(2)));
            chk("lock_no_yumi", 32'(req_cmd_yumi_o), 0);
        end
        cyc(); req_cmd_v_i = 4'b0101; io_cmd_yumi_i = 1'b1; #1;
        chk("lock_yumi", 32'(req_cmd_yumi_o), 32'b0100);
        cyc(); req_cmd_v_i = 4'b0001; io_cmd_yumi_i = 1'b1; #1;
        chk("lock_next_cmd", 32'(io_cmd_o), 32'(cmd(0)));
        chk("lock_next_yumi", 32'(req_cmd_yumi_o), 32'b0001);

        // rr_ptr=1: lock on 2, then requester 1 appears and must not displace it.
        cyc(); req_cmd_v_i = 4'b0100; #1;
        chk("lock2_cmd", 32'(io_cmd_o), 32'(cmd(2)));
        cyc(); req_cmd_v_i = 4'b0110; io_cmd_yumi_i = 1'b1; #1;
        chk("lock2_hold", 32'(io_cmd_o), 32'(cmd(2)));
        chk("lock2_yumi", 32'(req_cmd_yumi_o), 32'b0100);

        for (int s = 0; s < 3; s++) begin
            cyc(); io_resp_v_i = 1'b1; #1;
            chk("order_resp_v", 32'(req_resp_v_o), oh(heads_a[s]));
        end

        // Credit limit: four issues fill the FIFO (grants 3,0,1,2).
        for (int s = 0; s < 4; s++) begin
            cyc(); req_cmd_v_i = '1; io_cmd_yumi_i = 1'b1; #1;
            chk("credit_yumi", 32'(req_cmd_yumi_o), oh((3 + s) % 4));
        end
        for (int s = 0; s < 2; s++) begin
            cyc(); req_cmd_v_i = '1; #1;
            chk("full_cmd_v", 32'(io_cmd_v_o), 0);
        end
        cyc(); req_cmd_v_i = '1; io_resp_v_i = 1'b1; #1;
        chk("full_pop_cmd_v", 32'(io_cmd_v_o), 0);
        chk("full_pop_resp_v", 32'(req_resp_v_o), 32'b1000);
        chk("full_pop_yumi", 32'(io_resp_yumi_o), 1);
        cyc(); req_cmd_v_i = '1; io_cmd_yumi_i = 1'b1; io_resp_v_i = 1'b1; #1;
        chk("both_cmd_v", 32'(io_cmd_v_o), 1);
        chk("both_yumi", 32'(req_cmd_yumi_o), 32'b1000);
        chk("both_resp_v", 32'(req_resp_v_o), 32'b0001);
        cyc(); req_cmd_v_i = '1; io_cmd_yumi_i = 1'b1; #1;
        chk("last_cmd_v", 32'(io_cmd_v_o), 1);
        chk("last_yumi", 32'(req_cmd_yumi_o), 32'b0001);
        cyc(); req_cmd_v_i = '1; #1;
        chk("refull_cmd_v", 32'(io_cmd_v_o), 0);

        // Response backpressure on head ID 1.
        for (int s = 0; s < 5; s++) begin
            cyc(); req_resp_ready_i = 4'b1101; io_resp_v_i = 1'b1; #1;
            chk("bp_resp_v", 32'(req_resp_v_o), 32'b0010);
            chk("bp_resp_yumi", 32'(io_resp_yumi_o), 0);
        end
        cyc(); io_resp_v_i = 1'b1; #1;
        chk("bp_release", 32'(io_resp_yumi_o), 1);
        for (int s = 0; s < 3; s++) begin
            cyc(); io_resp_v_i = 1'b1; #1;
            chk("bp_drain_v", 32'(req_resp_v_o), oh(heads_b[s]));
        end

        // Response with an empty FIFO.
        cyc(); io_resp_v_i = 1'b1; #1;
        chk("perr_resp_yumi", 32'(io_resp_yumi_o), 0);
        chk("perr_resp_v", 32'(req_resp_v_o), 0);
        chk("perr_err_same", 32'(error_o), 0);
        cyc(); #1;
        chk("perr_err_next", 32'(error_o), 1);
        cyc(); cyc(); #1;
        chk("perr_sticky", 32'(error_o), 1);

        // Async reset mid-stall with three outstanding (grants 1,2,3).
        for (int s = 0; s < 3; s++) begin
            cyc(); req_cmd_v_i = '1; io_cmd_yumi_i = 1'b1; #1;
            chk("ar_yumi", 32'(req_cmd_yumi_o), oh(1 + s));
        end
        cyc(); req_cmd_v_i = '1; #1;
        chk("ar_stall_v", 32'(io_cmd_v_o), 1);
        #2;
        reset_n_i     = 1'b0;
        io_cmd_yumi_i = 1'b1;
        io_resp_v_i   = 1'b1;
        #1;
        chk("ar_cmd_v", 32'(io_cmd_v_o), 0);
        chk("ar_cmd_yumi", 32'(req_cmd_yumi_o), 0);
        chk("ar_resp_v", 32'(req_resp_v_o), 0);
        chk("ar_resp_yumi", 32'(io_resp_yumi_o), 0);
        chk("ar_error", 32'(error_o), 0);
        cyc(); reset_n_i = 1'b1; req_cmd_v_i = '1; #1;
        chk("ar_rr0_cmd", 32'(io_cmd_o), 32'(cmd(0)));
        chk("ar_cmd_v_after", 32'(io_cmd_v_o), 1);
        cyc(); io_resp_v_i = 1'b1; #1;
        chk("ar_stale_resp_v", 32'(req_resp_v_o), 0);
        chk("ar_stale_yumi", 32'(io_resp_yumi_o), 0);
        cyc(); #1;
        chk("ar_stale_err", 32'(error_o), 1);

        // Downstream yumi without a valid command.
        #1; reset_n_i = 1'b0; #1; reset_n_i = 1'b1;
        cyc(); io_cmd_yumi_i = 1'b1; #1;
        chk("yerr_no_yumi", 32'(req_cmd_yumi_o), 0);
        chk("yerr_err_same", 32'(error_o), 0);
        cyc(); io_resp_v_i = 1'b1; #1;
        chk("yerr_err_next", 32'(error_o), 1);
        chk("yerr_no_push", 32'(req_resp_v_o), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
